sad_search_ctrl: RTL and testbench

Full-search motion-estimation sequencer for the 16x16 SAD engine. Walks every integer offset in a ±SR square search window in raster order, requests each candidate reference block from the fetch unit, and pulses the engine's `cal_en` when the block is present. Collects the pipelined SAD results and reports the minimum SAD with its motion vector. Sits between the ME top-level control and the SAD datapath; it is the engine's only driver.

---
 rtl/sad_search_ctrl_if.sv | 33 +++
 rtl/sad_search_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_sad_search_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sad_search_ctrl_if.sv
// -----------------------------------------------------------------------------
// sad_search_ctrl_if
// Link between the search sequencer and the SAD engine/fetch unit.
//   fetch_req          sequencer -> fetch : candidate request
//   fetch_x / fetch_y  sequencer -> fetch : signed candidate offset
//   fetch_rdy          fetch -> sequencer : block for the offset is on refi
//   cal_en             sequencer -> engine: engine start (request & ready)
//   sad_in             engine -> sequencer: SAD result (DWIDTH+8 bits)
//   sad_vld_in         engine -> sequencer: result valid
// Modports: master = sequencer side, slave = fetch/engine side.
// -----------------------------------------------------------------------------
interface sad_search_ctrl_if #(
  parameter int DWIDTH = 8,
  parameter int OFF_W  = 4
);
  logic                    fetch_req;
  logic signed [OFF_W-1:0] fetch_x;
  logic signed [OFF_W-1:0] fetch_y;
  logic                    fetch_rdy;
  logic                    cal_en;
  logic [DWIDTH+7:0]       sad_in;
  logic                    sad_vld_in;

  modport master (
    output fetch_req, fetch_x, fetch_y, cal_en,
    input  fetch_rdy, sad_in, sad_vld_in
  );

  modport slave (
    input  fetch_req, fetch_x, fetch_y, cal_en,
    output fetch_rdy, sad_in, sad_vld_in
  );
endinterface

// File: rtl/sad_search_ctrl.sv
// -----------------------------------------------------------------------------
// sad_search_ctrl
// Full-search motion-estimation sequencer for the 16x16 SAD engine. Walks all
// offsets of the +/-SR window in raster order, requests each candidate from
// the fetch unit, fires the engine on each handshake, tags the pipelined
// results with their offsets and reports the minimum SAD and its vector.
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   start              one-cycle pulse, begins a search when idle
//   sad_thr            early-termination threshold
//   busy               search in progress
//   eng (master)       fetch request/offset/ready, cal_en, SAD result/valid
//   best_sad           minimum SAD of the last search
//   best_x, best_y     signed offset of best_sad
//   done               one-cycle pulse, best_* valid until the next start
//
// Optional feature: define SAD_EARLY_TERM_EN to stop issuing once a returned
// SAD is <= sad_thr. Without it sad_thr is unused and all candidates are
// visited.
// -----------------------------------------------------------------------------
module sad_search_ctrl #(
  parameter int DWIDTH     = 8,
  parameter int PIPE_STAGE = 5,
  parameter int SR         = 4,
  parameter int OFF_W      = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic [DWIDTH+7:0]       sad_thr,
  output logic                    busy,
  sad_search_ctrl_if.master       eng,
  output logic [DWIDTH+7:0]       best_sad,
  output logic signed [OFF_W-1:0] best_x,
  output logic signed [OFF_W-1:0] best_y,
  output logic                    done
);

  localparam int SAD_W      = DWIDTH + 8;
  // At most PIPE_STAGE+1 results are outstanding, so this depth never fills.
  localparam int FIFO_DEPTH = PIPE_STAGE + 2;
  localparam int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic signed [OFF_W-1:0] POS_SR = OFF_W'(SR);
  localparam logic signed [OFF_W-1:0] NEG_SR = OFF_W'(-SR);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                  state_reg, state_next;
  logic signed [OFF_W-1:0] x_reg, y_reg;
  logic [7:0]              issued_reg, returned_reg, returned_next;
  logic [PTR_W-1:0]        wr_ptr_reg, rd_ptr_reg;
  logic signed [OFF_W-1:0] fifo_x_reg [FIFO_DEPTH];
  logic signed [OFF_W-1:0] fifo_y_reg [FIFO_DEPTH];
  logic [SAD_W-1:0]        min_reg, min_next;
  logic signed [OFF_W-1:0] min_x_reg, min_y_reg, min_x_next, min_y_next;
  logic [SAD_W-1:0]        best_sad_reg;
  logic signed [OFF_W-1:0] best_x_reg, best_y_reg;

  logic fetch_req_int;
  logic handshake;
  logic last_pos;
  logic vld_act;
  logic term_hit;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign handshake     = fetch_req_int & eng.fetch_rdy;
  assign last_pos      = (x_reg == POS_SR) && (y_reg == POS_SR);
  // Results are only meaningful while a search is running; stale engine
  // outputs arriving in IDLE (e.g. after a reset) are dropped.
  assign vld_act       = eng.sad_vld_in && ((state_reg == S_ISSUE) || (state_reg == S_DRAIN));
  assign returned_next = returned_reg + 8'(vld_act);

`ifdef SAD_EARLY_TERM_EN
  assign term_hit = vld_act && (eng.sad_in <= sad_thr);
`else
  logic sad_thr_unused;
  assign sad_thr_unused = ^sad_thr;
  assign term_hit       = 1'b0;
`endif

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start) state_next = S_ISSUE;
      S_ISSUE: if ((handshake && last_pos) || term_hit) state_next = S_DRAIN;
      // Leave as the final result arrives so done lines up with it.
      S_DRAIN: if (returned_next == issued_reg) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy          = 1'b0;
    fetch_req_int = 1'b0;
    done          = 1'b0;
    case (state_reg)
      S_ISSUE: begin
        busy          = 1'b1;
        fetch_req_int = 1'b1;
      end
      S_DRAIN: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // ------------------------------------------------------ result compare
  // Strict less-than plus in-order returns keeps the earliest candidate on ties.
  always_comb begin
    min_next   = min_reg;
    min_x_next = min_x_reg;
    min_y_next = min_y_reg;
    if (vld_act && (eng.sad_in < min_reg)) begin
      min_next   = eng.sad_in;
      min_x_next = fifo_x_reg[rd_ptr_reg];
      min_y_next = fifo_y_reg[rd_ptr_reg];
    end
  end

  // ----------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      x_reg        <= '0;
      y_reg        <= '0;
      issued_reg   <= '0;
      returned_reg <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      min_reg      <= '0;
      min_x_reg    <= '0;
      min_y_reg    <= '0;
      best_sad_reg <= '0;
      best_x_reg   <= '0;
      best_y_reg   <= '0;
    end else begin
      if ((state_reg == S_IDLE) && start) begin
        x_reg        <= NEG_SR;
        y_reg        <= NEG_SR;
        issued_reg   <= '0;
        returned_reg <= '0;
        wr_ptr_reg   <= '0;
        rd_ptr_reg   <= '0;
        min_reg      <= '1;
        min_x_reg    <= NEG_SR;
        min_y_reg    <= NEG_SR;
      end else begin
        if (handshake) begin
          issued_reg <= issued_reg + 8'd1;
          wr_ptr_reg <= ptr_inc(wr_ptr_reg);
          // The final offset is held rather than walked past +SR.
          if (!last_pos) begin
            if (x_reg == POS_SR) begin
              x_reg <= NEG_SR;
              y_reg <= y_reg + OFF_W'(1);
            end else begin
              x_reg <= x_reg + OFF_W'(1);
            end
          end
        end
        if (vld_act) begin
          returned_reg <= returned_next;
          rd_ptr_reg   <= ptr_inc(rd_ptr_reg);
          min_reg      <= min_next;
          min_x_reg    <= min_x_next;
          min_y_reg    <= min_y_next;
        end
      end
      // Publish on the edge entering DONE, including a result arriving now.
      if ((state_reg != S_DONE) && (state_next == S_DONE)) begin
        best_sad_reg <= min_next;
        best_x_reg   <= min_x_next;
        best_y_reg   <= min_y_next;
      end
    end
  end

  // Position tags written on issue, read in order on each result.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_x_reg[i] <= '0;
        fifo_y_reg[i] <= '0;
      end
    end else if (handshake) begin
      fifo_x_reg[wr_ptr_reg] <= x_reg;
      fifo_y_reg[wr_ptr_reg] <= y_reg;
    end
  end

  assign eng.fetch_req = fetch_req_int;
  assign eng.fetch_x   = x_reg;
  assign eng.fetch_y   = y_reg;
  assign eng.cal_en    = handshake;
  assign best_sad      = best_sad_reg;
  assign best_x        = best_x_reg;
  assign best_y        = best_y_reg;

endmodule

// File: tb/tb_sad_search_ctrl.sv
`timescale 1ns/1ps
// Bench for sad_search_ctrl: behavioural fetch/engine model with a SAD table
// indexed by raster candidate number, plus a first-minimum reference search.
module tb_sad_search_ctrl;
  localparam int DWIDTH     = 8;
  localparam int PIPE_STAGE = 5;
  localparam int SR         = 4;
  localparam int OFF_W      = 4;
  localparam int SIDE       = 2 * SR + 1;
  localparam int NCAND      = SIDE * SIDE;
  localparam int SAD_W      = DWIDTH + 8;
  localparam int LAT        = PIPE_STAGE + 1;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start = 1'b0;
  logic [SAD_W-1:0] sad_thr = '0;
  logic busy, done;
  logic [SAD_W-1:0] best_sad;
  logic signed [OFF_W-1:0] best_x, best_y;

  sad_search_ctrl_if #(.DWIDTH(DWIDTH), .OFF_W(OFF_W)) eng_if ();

  sad_search_ctrl #(
    .DWIDTH(DWIDTH), .PIPE_STAGE(PIPE_STAGE), .SR(SR), .OFF_W(OFF_W)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .sad_thr(sad_thr), .busy(busy),
    .eng(eng_if), .best_sad(best_sad), .best_x(best_x), .best_y(best_y), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int sad_tab [NCAND];

  function automatic int idx_of(input int x, input int y);
    return (y + SR) * SIDE + (x + SR);
  endfunction

  // Reference: earliest raster candidate holding the strict minimum.
  function automatic int ref_best();
    int bi = 0;
    for (int i = 1; i < NCAND; i++) if (sad_tab[i] < sad_tab[bi]) bi = i;
    return bi;
  endfunction

  // ------------------------------------------------ fetch/engine model
  logic cap_en = 1'b0;
  int   cap_idx = 0;
  always @(negedge clk) begin
    cap_en  = eng_if.cal_en;
    cap_idx = eng_if.cal_en ? idx_of($signed(eng_if.fetch_x), $signed(eng_if.fetch_y)) : 0;
  end

  logic pv [LAT];
  int   ps [LAT];
  initial begin
    for (int i = 0; i < LAT; i++) begin pv[i] = 1'b0; ps[i] = 0; end
    eng_if.sad_in = '0;
    eng_if.sad_vld_in = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rstn) begin
        for (int i = 0; i < LAT; i++) begin pv[i] = 1'b0; ps[i] = 0; end
      end else begin
        for (int i = LAT - 1; i > 0; i--) begin pv[i] = pv[i-1]; ps[i] = ps[i-1]; end
        pv[0] = cap_en;
        ps[0] = cap_en ? sad_tab[cap_idx] : 0;
      end
      eng_if.sad_vld_in = pv[LAT-1];
      eng_if.sad_in     = SAD_W'(ps[LAT-1]);
    end
  end

  // -------------------------------------------------- search observation
  int   iss_q [$];
  int   done_cnt, done_cyc, got_x, got_y;
  logic first_busy, first_req, busy_at_done;
  logic [SAD_W-1:0] got_sad;

  function automatic int first_order_err();
    for (int k = 0; k < iss_q.size(); k++) if (iss_q[k] != k) return k;
    return -1;
  endfunction

  // Cycle c is the c-th cycle after the edge that samples start.
  task automatic do_search(input int rdy_pct, input int restart_cyc, input int abort_cyc);
    int  c;
    bit  fin;
    iss_q.delete();
    done_cnt = 0; done_cyc = -1; got_x = 0; got_y = 0; got_sad = '0;
    first_busy = 1'b0; first_req = 1'b0; busy_at_done = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    c = 1; fin = 1'b0;
    while (!fin) begin
      eng_if.fetch_rdy = ($urandom_range(0, 99) < rdy_pct);
      start = (c == restart_cyc);
      if (c == abort_cyc) begin
        rstn = 1'b0;
        #1;
        fin = 1'b1;
      end else begin
        @(negedge clk);
        if (c == 1) begin first_busy = busy; first_req = eng_if.fetch_req; end
        if (eng_if.cal_en) iss_q.push_back(idx_of($signed(eng_if.fetch_x), $signed(eng_if.fetch_y)));
        if (done) begin
          done_cnt++;
          if (done_cyc < 0) begin
            done_cyc = c; busy_at_done = busy; got_sad = best_sad;
            got_x = $signed(best_x); got_y = $signed(best_y);
          end
        end
        if ((done_cyc >= 0 && c >= done_cyc + 4) || c >= 3000) fin = 1'b1;
        @(posedge clk); #1;
        c++;
      end
    end
    eng_if.fetch_rdy = 1'b0;
    start = 1'b0;
    $display("search: issues=%0d done_cnt=%0d done_cyc=%0d best_sad=%0d best=(%0d,%0d)",
             iss_q.size(), done_cnt, done_cyc, got_sad, got_x, got_y);
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    eng_if.fetch_rdy = 1'b1;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if ({busy, done, eng_if.fetch_req, eng_if.cal_en} !== 4'b0) begin
      n_bad++; $display("FAIL reset_ctl: got %b expected 0000", {busy, done, eng_if.fetch_req, eng_if.cal_en}); end
    n_cmp++; if ({best_sad, best_x, best_y} !== '0) begin
      n_bad++; $display("FAIL reset_best: got %h expected 0", {best_sad, best_x, best_y}); end
    n_cmp++; if ({eng_if.fetch_x, eng_if.fetch_y} !== '0) begin
      n_bad++; $display("FAIL reset_off: got %h expected 0", {eng_if.fetch_x, eng_if.fetch_y}); end
    @(posedge clk); #1 rstn = 1'b1; eng_if.fetch_rdy = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_uniform();
    for (int i = 0; i < NCAND; i++) sad_tab[i] = 100;
    do_search(100, 0, 0);
    n_cmp++; if ({first_busy, first_req} !== 2'b11) begin
      n_bad++; $display("FAIL uni_cycle1: got busy/req %b expected 11", {first_busy, first_req}); end
    n_cmp++; if (done_cyc !== NCAND + PIPE_STAGE + 2) begin
      n_bad++; $display("FAIL uni_done_cyc: got %0d expected %0d", done_cyc, NCAND + PIPE_STAGE + 2); end
    n_cmp++; if (busy_at_done !== 1'b0) begin
      n_bad++; $display("FAIL uni_busy_at_done: got %b expected 0", busy_at_done); end
    n_cmp++; if (iss_q.size() !== NCAND) begin
      n_bad++; $display("FAIL uni_issues: got %0d expected %0d", iss_q.size(), NCAND); end
    n_cmp++; if (first_order_err() !== -1) begin
      n_bad++; $display("FAIL uni_order: first bad position %0d expected none", first_order_err()); end
    n_cmp++; if (got_sad !== SAD_W'(100) || got_x !== -SR || got_y !== -SR) begin
      n_bad++; $display("FAIL uni_best: got %0d (%0d,%0d) expected 100 (%0d,%0d)", got_sad, got_x, got_y, -SR, -SR); end
  endtask

  task automatic test_unique_min();
    for (int i = 0; i < NCAND; i++) sad_tab[i] = 500;
    sad_tab[50] = 37;
    do_search(100, 0, 0);
    n_cmp++; if (got_sad !== SAD_W'(37) || got_x !== 1 || got_y !== 1) begin
      n_bad++; $display("FAIL umin_best: got %0d (%0d,%0d) expected 37 (1,1)", got_sad, got_x, got_y); end
    n_cmp++; if (done_cnt !== 1) begin
      n_bad++; $display("FAIL umin_done_cnt: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < NCAND; i++) sad_tab[i] = int'($urandom_range(100, 1000));
    sad_tab[NCAND-1] = 50;
    do_search(50, 0, 0);
    n_cmp++; if (iss_q.size() !== NCAND) begin
      n_bad++; $display("FAIL bp_issues: got %0d expected %0d", iss_q.size(), NCAND); end
    n_cmp++; if (first_order_err() !== -1) begin
      n_bad++; $display("FAIL bp_order: first bad position %0d expected none", first_order_err()); end
    n_cmp++; if (got_sad !== SAD_W'(50) || got_x !== SR || got_y !== SR) begin
      n_bad++; $display("FAIL bp_best: got %0d (%0d,%0d) expected 50 (%0d,%0d)", got_sad, got_x, got_y, SR, SR); end
    n_cmp++; if (done_cnt !== 1) begin
      n_bad++; $display("FAIL bp_done_cnt: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_busy_start();
    int bi;
    for (int i = 0; i < NCAND; i++) sad_tab[i] = int'($urandom_range(1, 300));
    bi = ref_best();
    do_search(100, 20, 0);
    n_cmp++; if (done_cnt !== 1) begin
      n_bad++; $display("FAIL busy_done_cnt: got %0d expected 1", done_cnt); end
    n_cmp++; if (iss_q.size() !== NCAND) begin
      n_bad++; $display("FAIL busy_issues: got %0d expected %0d", iss_q.size(), NCAND); end
    n_cmp++; if (done_cyc !== NCAND + PIPE_STAGE + 2) begin
      n_bad++; $display("FAIL busy_done_cyc: got %0d expected %0d", done_cyc, NCAND + PIPE_STAGE + 2); end
    n_cmp++; if (got_sad !== SAD_W'(sad_tab[bi]) || got_x !== bi % SIDE - SR || got_y !== bi / SIDE - SR) begin
      n_bad++; $display("FAIL busy_best: got %0d (%0d,%0d) expected %0d (%0d,%0d)",
                        got_sad, got_x, got_y, sad_tab[bi], bi % SIDE - SR, bi / SIDE - SR); end
  endtask

  task automatic test_reset_mid();
    int bi;
    for (int i = 0; i < NCAND; i++) sad_tab[i] = int'($urandom_range(1, 400));
    do_search(100, 0, 40);
    n_cmp++; if ({busy, done, eng_if.fetch_req, eng_if.cal_en} !== 4'b0) begin
      n_bad++; $display("FAIL rmid_ctl: got %b expected 0000", {busy, done, eng_if.fetch_req, eng_if.cal_en}); end
    n_cmp++; if ({best_sad, best_x, best_y, eng_if.fetch_x, eng_if.fetch_y} !== '0) begin
      n_bad++; $display("FAIL rmid_data: got %h expected 0", {best_sad, best_x, best_y, eng_if.fetch_x, eng_if.fetch_y}); end
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (10) @(posedge clk);
    // Small value range forces ties, exercising the earliest-wins rule.
    for (int i = 0; i < NCAND; i++) sad_tab[i] = int'($urandom_range(1, 20));
    bi = ref_best();
    do_search(70, 0, 0);
    n_cmp++; if (iss_q.size() !== NCAND || first_order_err() !== -1) begin
      n_bad++; $display("FAIL rmid_issues: got %0d (order err %0d) expected %0d in order",
                        iss_q.size(), first_order_err(), NCAND); end
    n_cmp++; if (got_sad !== SAD_W'(sad_tab[bi]) || got_x !== bi % SIDE - SR || got_y !== bi / SIDE - SR) begin
      n_bad++; $display("FAIL rmid_best: got %0d (%0d,%0d) expected %0d (%0d,%0d)",
                        got_sad, got_x, got_y, sad_tab[bi], bi % SIDE - SR, bi / SIDE - SR); end
  endtask

`ifdef SAD_EARLY_TERM_EN
  task automatic test_early_term();
    for (int i = 0; i < NCAND; i++) sad_tab[i] = 200;
    sad_tab[3] = 5;
    sad_thr = SAD_W'(10);
    do_search(100, 0, 0);
    sad_thr = '0;
    // Candidate 3 returns in cycle 3+1+LAT; every handshake up to then counts.
    n_cmp++; if (iss_q.size() !== 3 + LAT + 1) begin
      n_bad++; $display("FAIL et_issues: got %0d expected %0d", iss_q.size(), 3 + LAT + 1); end
    n_cmp++; if (got_sad !== SAD_W'(5) || got_x !== -1 || got_y !== -4) begin
      n_bad++; $display("FAIL et_best: got %0d (%0d,%0d) expected 5 (-1,-4)", got_sad, got_x, got_y); end
    n_cmp++; if (done_cnt !== 1) begin
      n_bad++; $display("FAIL et_done_cnt: got %0d expected 1", done_cnt); end
  endtask
`endif

  initial begin
    eng_if.fetch_rdy = 1'b0;
    test_reset();
    test_uniform();
    test_unique_min();
    test_backpressure();
    test_busy_start();
    test_reset_mid();
`ifdef SAD_EARLY_TERM_EN
    test_early_term();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
